// File: rtl/posit_stream_decoder.sv
// Two-stage valid/ready posit(n, es) decoder: sign, zero/NaR flags, signed scale, hidden-bit mantissa.
// Optional NaR/zero delivery counters are built when PDPU_DEC_STATS_EN is defined.
module posit_stream_decoder #(
    parameter int n  = 16,
    parameter int es = 1,
    localparam int SCALE_WIDTH = $clog2(n) + 1 + es,
    localparam int MANT_WIDTH  = n - es - 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [n-1:0]                  operand_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          sign_o,
    output logic                          zero_o,
    output logic                          nar_o,
    output logic signed [SCALE_WIDTH-1:0] scale_o,
    output logic [MANT_WIDTH:0]           mant_o,
    output logic [15:0]                   nar_cnt_o,
    output logic [15:0]                   zero_cnt_o
);
    localparam int CW = $clog2(n) + 1;

    // Handshake: a word moves on in_valid_i & in_ready_o and leaves on out_valid_o & out_ready_i;
    // each stage advances when it is empty or the stage after it is advancing.
    logic s1_en, s2_en;
    logic s1_valid, s1_sign, s1_zero, s1_nar;
    logic [n-2:0] s1_body;
    logic s2_valid, s2_sign, s2_zero, s2_nar;
    logic [SCALE_WIDTH-1:0] s2_scale;
    logic [MANT_WIDTH:0] s2_mant;

    assign s2_en      = !s2_valid || out_ready_i;
    assign s1_en      = !s1_valid || s2_en;
    assign in_ready_o = s1_en;

    logic [n-2:0] in_body;
    logic         in_zero, in_nar;

    // Only the bits below the sign of the magnitude are kept; for non-NaR words its MSB is 0.
    assign in_body = operand_i[n-1] ? (~operand_i[n-2:0] + (n-1)'(1)) : operand_i[n-2:0];
    assign in_zero = (operand_i == '0);
    assign in_nar  = operand_i[n-1] && (operand_i[n-2:0] == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_body  <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sign <= operand_i[n-1];
                s1_zero <= in_zero;
                s1_nar  <= in_nar;
                s1_body <= in_body;
            end
        end
    end

    logic                   run_bit, run_on;
    logic [CW-1:0]          run_len;
    logic [n-2:0]           after_run;
    logic [SCALE_WIDTH-1:0] k_val, e_val, d_scale;
    logic [MANT_WIDTH-1:0]  frac;

    always_comb begin
        run_bit = s1_body[n-2];
        run_on  = 1'b1;
        run_len = '0;
        for (int i = n - 2; i >= 0; i--) begin
            if (run_on && (s1_body[i] == run_bit)) run_len = run_len + CW'(1);
            else                                   run_on  = 1'b0;
        end
        // A run filling every bit shifts everything out, leaving e = 0 and fraction = 0.
        after_run = s1_body << (run_len + CW'(1));
        e_val     = SCALE_WIDTH'(after_run >> (n - 1 - es));
        frac      = MANT_WIDTH'(after_run >> (n - 1 - es - MANT_WIDTH));
        k_val     = run_bit ? (SCALE_WIDTH'(run_len) - SCALE_WIDTH'(1))
                            : (SCALE_WIDTH'(0) - SCALE_WIDTH'(run_len));
        d_scale   = (k_val << es) + e_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_nar   <= 1'b0;
            s2_scale <= '0;
            s2_mant  <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_zero <= s1_zero;
                s2_nar  <= s1_nar;
                if (s1_zero || s1_nar) begin
                    s2_sign  <= 1'b0;
                    s2_scale <= '0;
                    s2_mant  <= '0;
                end else begin
                    s2_sign  <= s1_sign;
                    s2_scale <= d_scale;
                    s2_mant  <= {1'b1, frac};
                end
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign sign_o      = s2_sign;
    assign zero_o      = s2_zero;
    assign nar_o       = s2_nar;
    assign scale_o     = $signed(s2_scale);
    assign mant_o      = s2_mant;

`ifdef PDPU_DEC_STATS_EN
    logic [15:0] nar_cnt, zero_cnt;
    logic        out_fire;

    assign out_fire = s2_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nar_cnt  <= '0;
            zero_cnt <= '0;
        end else if (out_fire) begin
            if (s2_nar && (nar_cnt != 16'hFFFF))   nar_cnt  <= nar_cnt + 16'd1;
            if (s2_zero && (zero_cnt != 16'hFFFF)) zero_cnt <= zero_cnt + 16'd1;
        end
    end

    assign nar_cnt_o  = nar_cnt;
    assign zero_cnt_o = zero_cnt;
`else
    assign nar_cnt_o  = 16'd0;
    assign zero_cnt_o = 16'd0;
`endif

endmodule

// File: doc/posit_stream_decoder.md
# posit_stream_decoder

Pipelined, valid/ready streaming posit decoder: accepts one posit(n, es) word per cycle and returns its unpacked fields (sign, zero/NaR flags, combined signed scale, normalised mantissa with hidden bit). It is the inverse of the posit encoder at the dot-product unit output. It sits downstream of the dot-product unit, so results can be inspected, re-scaled or fed back as operands. Two register stages with full backpressure sustain one decode per cycle.

## Interface
- `n`, 16: posit width.
- `es`, 1: exponent field width; 0 is legal.
- `SCALE_WIDTH`, clog2(n)+1+es: width of the signed scale output, derived and not overridden.
- `MANT_WIDTH`, n-es-3: maximum fraction bits; the mantissa output is MANT_WIDTH+1 bits. Derived.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `in_valid_i`, in, 1: input word valid.
- `in_ready_o`, out, 1: decoder can accept the input word.
- `operand_i`, in, n: posit word.
- `out_valid_o`, out, 1: decoded result valid.
- `out_ready_i`, in, 1: downstream accepts the result.
- `sign_o`, out, 1: sign of the value.
- `zero_o`, out, 1: operand was 0.
- `nar_o`, out, 1: operand was NaR (1 followed by n-1 zeros).
- `scale_o`, out, SCALE_WIDTH, signed: k·2^es + e.
- `mant_o`, out, MANT_WIDTH+1: hidden bit at the MSB, fraction MSB-aligned, zero-padded.
- `nar_cnt_o`, out, 16: NaR results delivered (see Configuration).
- `zero_cnt_o`, out, 16: zero results delivered (see Configuration).

## Operation
- Stage 1 (S1) captures the input on an input handshake (in_valid_i & in_ready_o).
  - Zero and NaR are detected here.
  - The magnitude is stored: two's complement of the word when the sign is 1, the word itself otherwise.
- Stage 2 (S2) processes the n-1 bits below the sign of the magnitude:
  - Regime bit r = MSB. m = length of the run of bits equal to r.
  - k = m-1 if r = 1; k = -m if r = 0.
  - The run plus its terminating bit are shifted out. The next es bits are e; bits missing past the LSB read as 0. The remaining bits form the fraction.
  - A run filling all n-1 bits gives k = n-2 (r = 1) or k = -(n-1) (r = 0), with no terminator, e = 0 and fraction 0.
  - scale_o = (k << es) + e, computed at SCALE_WIDTH bits signed.
  - mant_o = {1'b1, fraction, zero pad}.
- Zero result: zero_o = 1; sign_o, scale_o and mant_o are all 0.
- NaR result: nar_o = 1; sign_o, scale_o and mant_o are all 0.
- Decoding is exact; no rounding is performed.

## Timing
- Latency is 2 cycles from the input handshake to out_valid_o, when no stall occurs. Throughput is 1 word/cycle.
- Enables:
  - s2_en = !s2_valid | out_ready_i
  - s1_en = !s1_valid | s2_en
  - in_ready_o = s1_en. This is a combinational path from out_ready_i, which is accepted.
- Once out_valid_o is asserted, it and all result outputs hold stable until out_ready_i is sampled high.
- When an input and an output handshake occur in the same cycle with both stages full, both stages advance and no bubble is inserted.
- Reset:
  - All valid flags, data registers and counters clear to 0 on the clock edge where rst_i = 1.
  - in_ready_o = 1 after reset.
  - Words in flight when reset is applied are discarded; no partial output appears.
- in_valid_i is ignored while in_ready_o = 0. The upstream is responsible for holding the word.

## Configuration
- `PDPU_DEC_STATS_EN` defined:
  - nar_cnt_o and zero_cnt_o each increment by 1 on every output handshake whose nar_o or zero_o, respectively, is 1.
  - Both counters saturate at 0xFFFF and clear only on reset.
- Macro undefined: the counter ports remain present, are tied to 0, and no counter flops are built.

## Test plan
- n=16, es=1, in 0x4000 with out_ready_i held high → result after 2 cycles: sign 0, scale 0, mant 0x1000.
- 0x4800 → scale 0, mant 0x1800 (1.5). 0x5000 → scale 1, mant 0x1000. 0xC000 → sign 1, scale 0, mant 0x1000.
- 0x7FFF → scale 28, mant 0x1000. 0x0001 → scale -28. 0x0000 → zero_o = 1. 0x8000 → nar_o = 1, other fields 0.
- Back-to-back inputs for 8 cycles with out_ready_i low on cycles 3–5:
  - in_ready_o drops once both stages are full.
  - Outputs hold stable while stalled.
  - All 8 results arrive in order, with no loss and no duplicates.
- rst_i pulsed with both stages valid → the next cycle shows out_valid_o = 0, outputs and counters at 0, and in_ready_o = 1.
- With PDPU_DEC_STATS_EN defined, stream 3 NaR and 2 zero words → nar_cnt_o = 3, zero_cnt_o = 2. Without the macro, both counters read 0.
